sevenseg_capture_decoder: RTL and testbench

- Receive-side counterpart to the team's seven-segment drivers. It samples the seven segment lines {a,b,c,d,e,f,g} coming from a driven display or another board, and waits until the pattern has been stable for a programmable time.
- It then decodes the stable pattern to a hex digit, or flags it as blank or invalid, and presents the result on a valid/ready output port.
- It is used for loopback self-test of display drivers and for reading displays on external boards.

---
 rtl/sevenseg_capture_decoder.sv | 154 +++++++++++++++
 tb/tb_sevenseg_capture_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_capture_decoder.sv
// Samples asynchronous seven-segment lines, waits for a stable pattern, decodes it
// to a hex digit / blank / invalid flag and presents it on a one-entry valid/ready port.
module sevenseg_capture_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_in,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_digit,
   output logic       out_blank,
   output logic       out_err,
   output logic [6:0] out_raw,
   output logic       ovf,
   input  logic       ovf_clr
);

   localparam logic [6:0]  SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES - 1);

   logic [6:0]  sync1_q, sync1_d, sync2_q, sync2_d;
   logic [6:0]  cand_q, cand_d, last_q, last_d;
   logic [15:0] cnt_q, cnt_d;
   logic        have_last_q, have_last_d;
   logic        out_valid_q, out_valid_d;
   logic [3:0]  out_digit_q, out_digit_d;
   logic        out_blank_q, out_blank_d;
   logic        out_err_q, out_err_d;
   logic [6:0]  out_raw_q, out_raw_d;
   logic        ovf_q, ovf_d;

   logic [6:0]  norm;
   logic        accept;
   logic        ovf_set;
   logic [3:0]  dec_digit;
   logic        dec_blank;
   logic        dec_err;

   // Decode the candidate, which equals the pattern being accepted in the accept cycle.
   always_comb begin
      dec_digit = 4'h0;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      case (cand_q)
         7'h7E: dec_digit = 4'h0;
         7'h30: dec_digit = 4'h1;
         7'h6D: dec_digit = 4'h2;
         7'h79: dec_digit = 4'h3;
         7'h33: dec_digit = 4'h4;
         7'h5B: dec_digit = 4'h5;
         7'h5F: dec_digit = 4'h6;
         7'h70: dec_digit = 4'h7;
         7'h7F: dec_digit = 4'h8;
         7'h7B: dec_digit = 4'h9;
         7'h77: dec_digit = 4'hA;
         7'h1F: dec_digit = 4'hB;
         7'h4E: dec_digit = 4'hC;
         7'h3D: dec_digit = 4'hD;
         7'h4F: dec_digit = 4'hE;
         7'h47: dec_digit = 4'hF;
         7'h00: dec_blank = 1'b1;
         default: dec_err = 1'b1;
      endcase
   end

   always_comb begin
      sync1_d     = seg_in;
      sync2_d     = sync1_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      have_last_d = have_last_q;
      out_valid_d = out_valid_q;
      out_digit_d = out_digit_q;
      out_blank_d = out_blank_q;
      out_err_d   = out_err_q;
      out_raw_d   = out_raw_q;
      ovf_set     = 1'b0;

      norm = ACTIVE_LOW ? ~sync2_q : sync2_q;

      // The counter saturates so a long-held pattern keeps satisfying the count,
      // and the last/have_last guard is what prevents re-reporting it.
      if (norm != cand_q) begin
         cand_d = norm;
         cnt_d  = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + 16'd1;
      end

      accept = (norm == cand_q) && (cnt_q == CNT_MAX) &&
               (!have_last_q || (cand_q != last_q));

      if (accept) begin
         last_d      = cand_q;
         have_last_d = 1'b1;
         if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            out_digit_d = dec_digit;
            out_blank_d = dec_blank;
            out_err_d   = dec_err;
            out_raw_d   = cand_q;
         end else begin
            ovf_set = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (ovf_set) ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
      else ovf_d = ovf_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= SEG_OFF;
         sync2_q     <= SEG_OFF;
         cand_q      <= '0;
         cnt_q       <= '0;
         last_q      <= '0;
         have_last_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_digit_q <= '0;
         out_blank_q <= 1'b0;
         out_err_q   <= 1'b0;
         out_raw_q   <= '0;
         ovf_q       <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         have_last_q <= have_last_d;
         out_valid_q <= out_valid_d;
         out_digit_q <= out_digit_d;
         out_blank_q <= out_blank_d;
         out_err_q   <= out_err_d;
         out_raw_q   <= out_raw_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_digit = out_digit_q;
   assign out_blank = out_blank_q;
   assign out_err   = out_err_q;
   assign out_raw   = out_raw_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_sevenseg_capture_decoder.sv
// Bench for sevenseg_capture_decoder: directed scenarios with literal expectations,
// then random segment traffic compared every cycle against a run-length model.
module tb_sevenseg_capture_decoder;

   localparam int S  = 4;
   localparam bit AL = 1'b1;

   logic       clk;
   logic       rst;
   logic [6:0] seg_in;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_digit;
   logic       out_blank;
   logic       out_err;
   logic [6:0] out_raw;
   logic       ovf;
   logic       ovf_clr;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   sevenseg_capture_decoder #(.STABLE_CYCLES(S), .ACTIVE_LOW(AL)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_digit(out_digit), .out_blank(out_blank), .out_err(out_err),
      .out_raw(out_raw), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   logic [6:0] m_s1, m_s2, m_run_val, m_last, m_raw, m_norm;
   int         m_run_len;
   logic       m_have_last, m_valid, m_blank, m_err, m_ovf, m_ev, m_drop;
   logic [3:0] m_digit;

   function automatic logic [6:0] to_line(input logic [6:0] lit);
      return AL ? ~lit : lit;
   endfunction

   task automatic m_decode(input logic [6:0] p, output logic [3:0] d,
                           output logic b, output logic e);
      d = 4'h0; b = 1'b0; e = 1'b0;
      if (p == 7'h00) b = 1'b1;
      else begin
         e = 1'b1;
         for (int i = 0; i < 16; i++)
            if (tbl[i] == p) begin d = 4'(i); e = 1'b0; end
      end
   endtask

   // A pattern is accepted once it has been seen on S+1 consecutive edges and differs
   // from the last accepted one; after reset the all-zero candidate counts as one sighting.
   always @(posedge clk) begin
      if (rst) begin
         m_s1 = AL ? 7'h7F : 7'h00; m_s2 = m_s1;
         m_run_val = 7'h00; m_run_len = 1; m_have_last = 0; m_last = 7'h00;
         m_valid = 0; m_digit = 0; m_blank = 0; m_err = 0; m_raw = 0; m_ovf = 0;
      end else begin
         m_norm = AL ? ~m_s2 : m_s2;
         if (m_norm == m_run_val) begin
            if (m_run_len < 100000) m_run_len++;
         end else begin
            m_run_val = m_norm; m_run_len = 1;
         end
         m_ev   = (m_run_len >= S + 1) && (!m_have_last || m_run_val != m_last);
         m_drop = 0;
         if (m_ev) begin
            m_last = m_run_val; m_have_last = 1;
            if (!m_valid || out_ready) begin
               m_decode(m_run_val, m_digit, m_blank, m_err);
               m_raw = m_run_val; m_valid = 1;
            end else m_drop = 1;
         end else if (m_valid && out_ready) m_valid = 0;
         if (m_drop) m_ovf = 1;
         else if (ovf_clr) m_ovf = 0;
         m_s2 = m_s1; m_s1 = seg_in;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_valid", 32'(out_valid), 32'(m_valid));
         check("model_digit", 32'(out_digit), 32'(m_digit));
         check("model_blank", 32'(out_blank), 32'(m_blank));
         check("model_err",   32'(out_err),   32'(m_err));
         check("model_raw",   32'(out_raw),   32'(m_raw));
         check("model_ovf",   32'(ovf),       32'(m_ovf));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic wait_valid(input string name, input int exp_n);
      int n = 0;
      do begin
         @(posedge clk); n++;
         @(negedge clk);
      end while (!out_valid && n < 30);
      check(name, 32'(n), 32'(exp_n));
   endtask

   task automatic count_valid(input string name, input int cycles, input int exp_k);
      int k = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); @(negedge clk);
         if (out_valid) k++;
      end
      check(name, 32'(k), 32'(exp_k));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 0);
      check({tag, "_digit"}, 32'(out_digit), 0);
      check({tag, "_blank"}, 32'(out_blank), 0);
      check({tag, "_err"},   32'(out_err),   0);
      check({tag, "_raw"},   32'(out_raw),   0);
      check({tag, "_ovf"},   32'(ovf),       0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int hold;
      logic [6:0] lit;
      rst = 1; seg_in = 7'h7F; out_ready = 1; ovf_clr = 0;
      step(); chk_en = 1;
      step(); step();
      @(negedge clk); check_all_zero("reset");

      // Blank after reset: candidate 0 already matches, so acceptance comes on edge S.
      step(); rst = 0;
      wait_valid("rst_blank_latency", S);
      check("rst_blank_blank", 32'(out_blank), 1);
      check("rst_blank_digit", 32'(out_digit), 0);
      check("rst_blank_raw",   32'(out_raw),   0);
      count_valid("rst_blank_once", 12, 0);

      step(); seg_in = 7'h12;
      wait_valid("digit2_latency", S + 3);
      check("digit2_digit", 32'(out_digit), 2);
      check("digit2_raw",   32'(out_raw),   32'h6D);
      check("digit2_err",   32'(out_err),   0);
      count_valid("digit2_once", 20, 0);

      step(); seg_in = 7'b1000100;
      wait_valid("invalid_latency", S + 3);
      check("invalid_raw",   32'(out_raw),   32'h3B);
      check("invalid_err",   32'(out_err),   1);
      check("invalid_digit", 32'(out_digit), 0);
      check("invalid_blank", 32'(out_blank), 0);
      count_valid("invalid_once", 10, 0);

      step(); seg_in = 7'h00;
      step(); step(); seg_in = 7'b1000100;
      count_valid("glitch_no_event", 20, 0);

      step(); out_ready = 0; seg_in = to_line(7'h30);
      wait_valid("ovf_digit1_latency", S + 3);
      check("ovf_digit1", 32'(out_digit), 1);
      step(); step(); seg_in = to_line(7'h5B);
      repeat (15) step();
      @(negedge clk);
      check("ovf_hold_digit", 32'(out_digit), 1);
      check("ovf_hold_valid", 32'(out_valid), 1);
      check("ovf_set",        32'(ovf),       1);
      step(); out_ready = 1;
      step(); out_ready = 0;
      @(negedge clk);
      check("ovf_pop_valid", 32'(out_valid), 0);
      check("ovf_sticky",    32'(ovf),       1);
      step(); ovf_clr = 1;
      step(); ovf_clr = 0;
      @(negedge clk);
      check("ovf_cleared", 32'(ovf), 0);

      step(); out_ready = 1; seg_in = to_line(7'h79);
      step(); step(); step(); rst = 1;
      @(posedge clk); @(negedge clk);
      check_all_zero("rst_midcount");
      step(); rst = 0; out_ready = 0;
      wait_valid("rst_mid_relatency", S + 3);
      check("rst_mid_digit", 32'(out_digit), 3);
      step(); rst = 1;
      @(posedge clk); @(negedge clk);
      check_all_zero("rst_valid");
      step(); rst = 0; out_ready = 1;
      wait_valid("rst_valid_relatency", S + 3);
      check("rst_valid_digit", 32'(out_digit), 3);

      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         step();
         if (hold == 0) begin
            case ($urandom_range(0, 3))
               0: lit = 7'h00;
               1: lit = 7'($urandom_range(0, 127));
               default: lit = tbl[$urandom_range(0, 15)];
            endcase
            seg_in = to_line(lit);
            hold = $urandom_range(1, 10);
         end
         hold--;
         out_ready = ($urandom_range(0, 3) != 0);
         ovf_clr   = ($urandom_range(0, 7) == 0);
         rst       = ($urandom_range(0, 299) == 0);
      end
      step(); rst = 0;
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
